// File: rtl/bcd_6d_to_binary_20b_seq.sv
// bcd_6d_to_binary_20b_seq
// Iterative reverse double-dabble: converts an NDIG-digit packed BCD value to
// an NBIN-bit binary value, one bit per clock, with a start/done handshake.
//
// Ports:
//   clk          system clock
//   rstn_signal  asynchronous active-low reset
//   start_i      request pulse, sampled only while idle
//   bcd_i        packed BCD input, digit 0 in bits [3:0]
//   busy_o       high while a conversion is in progress (SHIFT/DONE)
//   done_o       one-cycle pulse; bin_o is valid in this cycle
//   bin_o        last conversion result, held until the next done_o
//   err_o        invalid-digit flag (only driven when BCD_DIGIT_CHECK_EN is defined)
//
// Optional feature macro: BCD_DIGIT_CHECK_EN
//   When defined, a start with any digit > 9 skips the shift phase and
//   finishes with bin_o = 0, err_o = 1 (done_o two cycles after the start
//   cycle). Without it err_o is tied low and no digit checking is done.
//
// Timing: start accepted at edge T, shifts at edges T+1..T+20 (the last one
// also enters DONE and loads bin_o), done_o high in the cycle after edge T+20,
// i.e. 21 cycles after the start cycle; back-to-back period is 22 cycles.

module bcd_6d_to_binary_20b_seq #(
    parameter int unsigned NDIG = 6,
    parameter int unsigned NBIN = 20
) (
    input  logic                clk,
    input  logic                rstn_signal,
    input  logic                start_i,
    input  logic [4*NDIG-1:0]   bcd_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [NBIN-1:0]     bin_o,
    output logic                err_o
);

    localparam int unsigned BCD_W  = 4 * NDIG;
    localparam int unsigned ITER_W = $clog2(NBIN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [BCD_W-1:0]    bcd_sr, bcd_nxt;
    logic [NBIN-1:0]     bin_sr, bin_nxt;
    logic [ITER_W-1:0]   iter, iter_nxt;
    logic                busy_nxt;
    logic                done_nxt;
    logic [NBIN-1:0]     bin_o_nxt;

    // One reverse double-dabble step computed from the current shift registers
    logic [BCD_W-1:0]    sh_bcd;
    logic [NBIN-1:0]     sh_bin;

`ifdef BCD_DIGIT_CHECK_EN
    logic                err_q, err_nxt;
    logic                bcd_bad;

    // Any nibble above 9 marks the request as invalid BCD
    always_comb begin
        bcd_bad = 1'b0;
        for (int k = 0; k < int'(NDIG); k++) begin
            if (bcd_i[4*k +: 4] > 4'd9) begin
                bcd_bad = 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    // Shift {bcd_sr,bin_sr} right by one, then subtract 3 from every digit >= 8
    always_comb begin
        sh_bin = {bcd_sr[0], bin_sr[NBIN-1:1]};
        sh_bcd = {1'b0, bcd_sr[BCD_W-1:1]};
        for (int k = 0; k < int'(NDIG); k++) begin
            if (sh_bcd[4*k+3]) begin
                sh_bcd[4*k +: 4] = sh_bcd[4*k +: 4] - 4'd3;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        bcd_nxt   = bcd_sr;
        bin_nxt   = bin_sr;
        iter_nxt  = iter;
        done_nxt  = 1'b0;
        bin_o_nxt = bin_o;
`ifdef BCD_DIGIT_CHECK_EN
        err_nxt   = err_q;
`endif

        case (state)
            S_IDLE: begin
                if (start_i) begin
`ifdef BCD_DIGIT_CHECK_EN
                    if (bcd_bad) begin
                        state_nxt = S_ERR;
                    end else begin
                        state_nxt = S_SHIFT;
                        bcd_nxt   = bcd_i;
                        bin_nxt   = '0;
                        iter_nxt  = '0;
                    end
`else
                    state_nxt = S_SHIFT;
                    bcd_nxt   = bcd_i;
                    bin_nxt   = '0;
                    iter_nxt  = '0;
`endif
                end
            end

            S_SHIFT: begin
                bcd_nxt  = sh_bcd;
                bin_nxt  = sh_bin;
                iter_nxt = iter + ITER_W'(1);
                if (iter == ITER_W'(NBIN - 1)) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                    bin_o_nxt = sh_bin;
`ifdef BCD_DIGIT_CHECK_EN
                    err_nxt   = 1'b0;
`endif
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            S_ERR: begin
                // Invalid-digit request: report without converting
                state_nxt = S_DONE;
                done_nxt  = 1'b1;
                bin_o_nxt = '0;
`ifdef BCD_DIGIT_CHECK_EN
                err_nxt   = 1'b1;
`endif
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn_signal) begin
        if (!rstn_signal) begin
            state  <= S_IDLE;
            bcd_sr <= '0;
            bin_sr <= '0;
            iter   <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            bin_o  <= '0;
`ifdef BCD_DIGIT_CHECK_EN
            err_q  <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            bcd_sr <= bcd_nxt;
            bin_sr <= bin_nxt;
            iter   <= iter_nxt;
            busy_o <= busy_nxt;
            done_o <= done_nxt;
            bin_o  <= bin_o_nxt;
`ifdef BCD_DIGIT_CHECK_EN
            err_q  <= err_nxt;
`endif
        end
    end

endmodule
